// File: rtl/arb_defs.sv
// Shared definitions for the two-requester mux arbiter: FSM state encodings and datapath width.
package arb_defs;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/bit8_2to1mux.sv
// 8-bit 2:1 datapath mux; sel=0 passes a, sel=1 passes b.
module bit8_2to1mux (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic [7:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb2_mux8_ctrl.sv
// Two-requester round-robin arbiter with bounded bursts driving a shared 8-bit mux and a
// one-entry registered output stage. Define ARB_FIXED_PRIO_EN to make requester 0 win IDLE ties.
module arb2_mux8_ctrl
  import arb_defs::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              mux_sel
);

  arb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_served;
  // Masks the new grantee's ready for the one bubble cycle after a grant-to-grant switch.
  logic              hold;

  logic [DATA_W-1:0] mux_y;
  logic              stage_free;
  logic              xfer0, xfer1, xfer;
  logic              own_id, own_valid, own_xfer, other_valid;
  logic [CNT_W:0]    cnt_inc;
  logic              burst_done;
  logic [CNT_W-1:0]  cnt_sat;
  logic              tie_to_0;

  bit8_2to1mux u_mux (
    .a   (in0_data),
    .b   (in1_data),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_comb begin
    stage_free  = !out_valid || out_ready;
    in0_ready   = (state == GRANT0) && !hold && stage_free;
    in1_ready   = (state == GRANT1) && !hold && stage_free;
    xfer0       = in0_valid && in0_ready;
    xfer1       = in1_valid && in1_ready;
    xfer        = xfer0 || xfer1;
    own_id      = (state == GRANT1);
    own_valid   = own_id ? in1_valid : in0_valid;
    other_valid = own_id ? in0_valid : in1_valid;
    own_xfer    = own_id ? xfer1 : xfer0;
    cnt_inc     = {1'b0, cnt} + 1'b1;
    // >= rather than == so a contender arriving after saturation still forces a switch.
    burst_done  = cnt_inc >= (CNT_W+1)'(MAX_BURST);
    cnt_sat     = burst_done ? CNT_W'(MAX_BURST) : cnt_inc[CNT_W-1:0];
`ifdef ARB_FIXED_PRIO_EN
    tie_to_0    = 1'b1;
`else
    tie_to_0    = last_served;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      hold        <= 1'b0;
      mux_sel     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= 1'b0;
    end else begin
      hold <= 1'b0;

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_src   <= mux_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (in0_valid && (!in1_valid || tie_to_0)) begin
            state   <= GRANT0;
            mux_sel <= 1'b0;
          end else if (in1_valid) begin
            state   <= GRANT1;
            mux_sel <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!own_valid) begin
            cnt         <= '0;
            last_served <= own_id;
            if (other_valid) begin
              state   <= own_id ? GRANT0 : GRANT1;
              mux_sel <= !own_id;
              hold    <= 1'b1;
            end else begin
              state   <= IDLE;
              mux_sel <= 1'b0;
            end
          end else if (own_xfer) begin
            if (burst_done && other_valid) begin
              state       <= own_id ? GRANT0 : GRANT1;
              mux_sel     <= !own_id;
              hold        <= 1'b1;
              cnt         <= '0;
              last_served <= own_id;
            end else begin
              cnt <= cnt_sat;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mux_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/arb2_mux8_ctrl.md
Name: arb2_mux8_ctrl

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit 2:1 mux datapath.
- Two sources, each with a valid/ready handshake and an 8-bit payload, compete for one downstream 8-bit channel.
- The block grants one source at a time (round-robin with a bounded burst) and drives the mux select.
- Output is registered: one-entry output stage with its own valid/ready.

Parameters:
- MAX_BURST, 4, max consecutive transfers per grant while the other requester waits; legal range 1..7.
- CNT_W, 3, burst counter width; must satisfy 2**CNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has data.
- in0_data  input  8  requester 0 payload.
- in0_ready  output  1  requester 0 transfer accepted this cycle.
- in1_valid  input  1  requester 1 has data.
- in1_data  input  8  requester 1 payload.
- in1_ready  output  1  requester 1 transfer accepted this cycle.
- out_valid  output  1  registered output holds a word.
- out_data  output  8  registered mux output.
- out_src  output  1  source of out_data (0 or 1).
- out_ready  input  1  downstream accepts out_data.
- mux_sel  output  1  select to the datapath mux; 0 selects in0_data, 1 selects in1_data.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset at any time, including mid-burst or mid-stall, immediately forces:
  - state=IDLE, out_valid=0, out_data=0, out_src=0, mux_sel=0;
  - burst count=0, last_served=1 (requester 0 wins first).
  - Any word held in the output stage is dropped.
- States: IDLE, GRANT0, GRANT1 (registered). mux_sel = 1 only in GRANT1, else 0.
- Ready: inX_ready = (state==GRANTX) && (!out_valid || out_ready). Always 0 in IDLE.
- Transfer: occurs when inX_valid && inX_ready. On the next edge out_data <= mux output, out_src <= X, out_valid <= 1.
- Output stage:
  - out_valid drops only on (out_ready && no new transfer).
  - out_data and out_src are stable while out_valid && !out_ready.
- Latency: from IDLE, a valid seen at cycle N gives grant at N+1, acceptance at N+1 (if the stage is free), and out_valid at N+2.
  - Back-to-back inside a grant: one word per cycle with out_ready held high.
- IDLE transitions:
  - only in0_valid -> GRANT0; only in1_valid -> GRANT1.
  - both valid -> grant the requester != last_served.
  - none -> stay IDLE.
- GRANTX transitions, evaluated each cycle:
  - Transfer and count+1==MAX_BURST and other valid -> GRANTother; count=0; last_served=X.
  - Transfer otherwise -> stay; count+=1, saturating at MAX_BURST.
  - inX_valid low -> GRANTother if other valid, else IDLE; count=0; last_served=X.
  - inX_valid high but stalled (ready low) -> stay; count unchanged.
- Every switch costs exactly one bubble cycle: the new grantee's ready rises the cycle after the state change.
- Burst limit with no contender: count saturates and the grant continues indefinitely.
- Simultaneous: on the same edge that out_ready consumes the current word, a new transfer may load the stage (no bubble).
- Neither requester ever waits more than MAX_BURST+1 accepted words of the other.

Optional Feature:
- ARB_FIXED_PRIO_EN defined:
  - IDLE with both valid always grants requester 0; last_served is ignored.
  - The burst limit still forces a switch to requester 1, so no starvation.
- Undefined: round-robin as above.

Decomposition:
- Shared package/include arb_defs:
  - state encodings IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10;
  - data width constant 8.
- Datapath: one instance of the existing bit8_2to1mux driven by mux_sel, with in0_data on the sel=0 leg.
- Control (FSM, burst counter, output register) stays in this module.

Test Plan:
- Reset, then in0_valid=1 with data 0xA5, out_ready=1 -> in0_ready=1 at cycle 1; out_valid=1, out_data=0xA5, out_src=0 at cycle 2.
- Both valid continuously, MAX_BURST=4, out_ready=1 -> out_src sequence 0,0,0,0,(bubble),1,1,1,1,(bubble),0...
- out_ready held 0 for 5 cycles with 0x3C in the stage -> out_data stays 0x3C, in0_ready=0; out_ready=1 -> next word loads the following cycle.
- in1 alone sends 10 words -> no switch, no bubbles, count saturates, all 10 words delivered in order.
- Reset asserted mid-burst with out_valid=1 -> out_valid, in*_ready and mux_sel fall without a clock edge; after release both valid -> requester 0 granted first.
- ARB_FIXED_PRIO_EN, both valid from IDLE after requester 0 was last served -> requester 0 granted; after 4 words requester 1 is granted.
